// File: rtl/varredura_matriz_param.sv
// varredura_matriz_param: row-multiplexed LED matrix scan driver.
// Walks an active-low one-hot row select at one row per DIV clocks and
// drives active-low column data from a double-buffered frame image.
// Modes (chaves): 00 off, 01 static, 10 blink, 11 horizontal scroll.
// Optional feature macro: VARREDURA_BLANKING_EN forces linhas/colunas to all 1
// on the first cycle of every row slot to suppress ghosting.
module varredura_matriz_param #(
    parameter int LINHAS  = 7,
    parameter int COLUNAS = 5,
    parameter int DIV     = 50000,
    parameter int PERIODO = 25
) (
    input  logic                       clock_50MHz,
    input  logic                       reset,
    input  logic [1:0]                 chaves,
    input  logic [LINHAS*COLUNAS-1:0]  padrao,
    input  logic                       carregar,
    output logic [LINHAS-1:0]          linhas,
    output logic [COLUNAS-1:0]         colunas
);

    localparam int N  = LINHAS * COLUNAS;
    localparam int CW = $clog2(DIV);
    localparam int RW = $clog2(LINHAS);
    localparam int OW = $clog2(COLUNAS);
    localparam int FW = (PERIODO > 1) ? $clog2(PERIODO) : 1;

    logic [1:0]         chaves_s1, chaves_s2;
    logic [CW-1:0]      cnt;
    logic [RW-1:0]      linha;
    logic [FW-1:0]      quadro;
    logic               fase;
    logic [OW-1:0]      desloc;
    logic [N-1:0]       sombra, ativo;
    logic [COLUNAS-1:0] linha_bits;
    logic [LINHAS-1:0]  linhas_d;
    logic [COLUNAS-1:0] colunas_d;
    logic               ligado, tick, fronteira, fim_periodo;

    // Any non-zero synchronised mode keeps the scan running.
    assign ligado      = (chaves_s2 != 2'b00);
    assign tick        = ligado && (cnt == CW'(DIV - 1));
    assign fronteira   = tick && (linha == RW'(LINHAS - 1));
    assign fim_periodo = fronteira && (quadro == FW'(PERIODO - 1));

    // Two-flop synchroniser for the asynchronous mode switches.
    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            chaves_s1 <= 2'b00;
            chaves_s2 <= 2'b00;
        end else begin
            chaves_s1 <= chaves;
            chaves_s2 <= chaves_s1;
        end
    end

    // Prescaler and row counter; both parked at 0 while the mode is off.
    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            linha <= '0;
        end else if (!ligado) begin
            cnt   <= '0;
            linha <= '0;
        end else if (tick) begin
            cnt   <= '0;
            linha <= fronteira ? '0 : linha + 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

    // Frame counter, blink phase and scroll offset, stepped at frame boundaries.
    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            quadro <= '0;
            fase   <= 1'b0;
            desloc <= '0;
        end else if (!ligado) begin
            quadro <= '0;
            fase   <= 1'b0;
            desloc <= '0;
        end else if (fim_periodo) begin
            quadro <= '0;
            fase   <= ~fase;
            desloc <= (desloc == OW'(COLUNAS - 1)) ? '0 : desloc + 1'b1;
        end else if (fronteira) begin
            quadro <= quadro + 1'b1;
        end
    end

    // Double buffer: shadow captures padrao, active takes the old shadow at
    // the frame boundary so a frame is never torn.
    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            sombra <= '0;
            ativo  <= '0;
        end else begin
            if (carregar)  sombra <= padrao;
            if (fronteira) ativo  <= sombra;
        end
    end

    // Pixels of the row currently being scanned.
    always_comb begin
        linha_bits = '0;
        for (int r = 0; r < LINHAS; r++) begin
            if (linha == RW'(r)) linha_bits = ativo[r*COLUNAS +: COLUNAS];
        end
    end

    // Next output values from the current row and mode state.
    always_comb begin
        logic [OW:0] soma;
        linhas_d  = '1;
        colunas_d = '1;
        soma      = '0;
        if (ligado) begin
            for (int i = 0; i < LINHAS; i++) begin
                linhas_d[i] = (linha != RW'(i));
            end
            case (chaves_s2)
                2'b01:   colunas_d = ~linha_bits;
                2'b10:   colunas_d = fase ? '1 : ~linha_bits;
                default: begin
                    for (int c = 0; c < COLUNAS; c++) begin
                        soma = (OW+1)'(c) + {1'b0, desloc};
                        if (soma >= (OW+1)'(COLUNAS)) soma = soma - (OW+1)'(COLUNAS);
                        colunas_d[c] = ~linha_bits[soma[OW-1:0]];
                    end
                end
            endcase
`ifdef VARREDURA_BLANKING_EN
            if (cnt == '0) begin
                linhas_d  = '1;
                colunas_d = '1;
            end
`endif
        end
    end

    // Registered matrix outputs; all dark in reset.
    always_ff @(posedge clock_50MHz or posedge reset) begin
        if (reset) begin
            linhas  <= '1;
            colunas <= '1;
        end else begin
            linhas  <= linhas_d;
            colunas <= colunas_d;
        end
    end

endmodule

// File: tb/tb_varredura_matriz_param.sv
// Bench for varredura_matriz_param (LINHAS=7, COLUNAS=5, DIV=4, PERIODO=2).
// A reference model tracks elapsed scan cycles since leaving off and derives
// row, frame, blink phase and scroll offset from that count arithmetically.
module tb_varredura_matriz_param;

    localparam int L = 7;
    localparam int C = 5;
    localparam int D = 4;
    localparam int P = 2;
    localparam int N = L * C;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   chaves;
    logic [N-1:0] padrao;
    logic         carregar;
    logic [L-1:0] linhas;
    logic [C-1:0] colunas;

    int checks = 0;
    int errors = 0;

    varredura_matriz_param #(.LINHAS(L), .COLUNAS(C), .DIV(D), .PERIODO(P)) dut (
        .clock_50MHz(clk),
        .reset      (rst),
        .chaves     (chaves),
        .padrao     (padrao),
        .carregar   (carregar),
        .linhas     (linhas),
        .colunas    (colunas)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    // Reference model
    int           m_t;
    logic [1:0]   m_s1, m_s2;
    logic [N-1:0] m_sombra, m_ativo;
    logic [L-1:0] exp_lin;
    logic [C-1:0] exp_col;
    int           m_row, m_per, m_off;
    logic [C-1:0] m_pix;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_s1 = 2'b00; m_s2 = 2'b00;
            m_sombra = '0; m_ativo = '0;
            exp_lin = '1; exp_col = '1;
        end else begin
            // output register sees the state from before this edge
            m_row = (m_t / D) % L;
            m_per = m_t / (L * D * P);
            m_off = m_per % C;
            m_pix = m_ativo[m_row*C +: C];
            exp_lin = '1;
            exp_col = '1;
            if (m_s2 != 2'b00) begin
                exp_lin[m_row] = 1'b0;
                if (m_s2 == 2'b01) exp_col = ~m_pix;
                else if (m_s2 == 2'b10) exp_col = (m_per % 2 == 1) ? '1 : ~m_pix;
                else for (int c = 0; c < C; c++) exp_col[c] = ~m_pix[(c + m_off) % C];
`ifdef VARREDURA_BLANKING_EN
                if (m_t % D == 0) begin exp_lin = '1; exp_col = '1; end
`endif
            end
            // state update
            if (m_s2 != 2'b00) begin
                if (m_t % (L * D) == L * D - 1) m_ativo = m_sombra;
                m_t = m_t + 1;
            end else begin
                m_t = 0;
            end
            if (carregar) m_sombra = padrao;
            m_s2 = m_s1;
            m_s1 = chaves;
        end
    end

    // Driver helpers
    task automatic rand_img(output logic [N-1:0] img);
        logic [63:0] r64;
        r64 = {$urandom, $urandom};
        img = r64[N-1:0];
    endtask

    // Scenarios (each enters and leaves at a falling edge)
    task automatic test_reset;
        #1;
        checks++;
        if (linhas !== 7'h7F || colunas !== 5'h1F) begin
            errors++;
            $display("FAIL reset_initial linhas=%h colunas=%h expected 7f 1f", linhas, colunas);
        end
        @(negedge clk);
        rst = 1'b0;
        chaves = 2'b01;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            checks++;
            if (linhas !== exp_lin || colunas !== exp_col) begin
                errors++;
                $display("FAIL reset_scan i=%0d linhas=%h colunas=%h expected %h %h", i, linhas, colunas, exp_lin, exp_col);
            end
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (linhas !== 7'h7F || colunas !== 5'h1F) begin
            errors++;
            $display("FAIL reset_midscan linhas=%h colunas=%h expected 7f 1f", linhas, colunas);
        end
        chaves = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if (linhas !== 7'h7F || colunas !== 5'h1F || linhas !== exp_lin || colunas !== exp_col) begin
                errors++;
                $display("FAIL off_hold i=%0d linhas=%h colunas=%h expected 7f 1f", i, linhas, colunas);
            end
        end
    endtask

    task automatic test_static_load;
        int lit;
        lit = 0;
        chaves = 2'b01; padrao = 35'h1; carregar = 1'b1;
        for (int i = 0; i < 58; i++) begin
            @(negedge clk);
            if (i == 0) carregar = 1'b0;
            checks++;
            if (linhas !== exp_lin || colunas !== exp_col) begin
                errors++;
                $display("FAIL static_model i=%0d linhas=%h colunas=%h expected %h %h", i, linhas, colunas, exp_lin, exp_col);
            end
            if (linhas === 7'h7E && colunas === 5'h1E) lit++;
            checks++;
            if (linhas !== 7'h7E && colunas !== 5'h1F) begin
                errors++;
                $display("FAIL static_dark_rows i=%0d linhas=%h colunas=%h expected colunas 1f", i, linhas, colunas);
            end
        end
        checks++;
        if (lit !== 4) begin
            errors++;
            $display("FAIL static_row0_cycles got %0d expected 4", lit);
        end
    endtask

    task automatic test_tear_free;
        int lit;
        lit = 0;
        padrao = 35'h0; carregar = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            carregar = (i == 0);
            checks++;
            if (linhas !== exp_lin || colunas !== exp_col) begin
                errors++;
                $display("FAIL tear_model i=%0d linhas=%h colunas=%h expected %h %h", i, linhas, colunas, exp_lin, exp_col);
            end
            if (linhas === 7'h7E && colunas === 5'h1E) lit++;
        end
        carregar = 1'b0;
        checks++;
        if (lit !== 4) begin
            errors++;
            $display("FAIL tear_row0_cycles got %0d expected 4", lit);
        end
    endtask

    task automatic test_blink;
        int on_cycles;
        on_cycles = 0;
        chaves = 2'b10; padrao = '1; carregar = 1'b1;
        for (int i = 0; i < 254; i++) begin
            @(negedge clk);
            carregar = 1'b0;
            checks++;
            if (linhas !== exp_lin || colunas !== exp_col) begin
                errors++;
                $display("FAIL blink_model i=%0d linhas=%h colunas=%h expected %h %h", i, linhas, colunas, exp_lin, exp_col);
            end
            if (i >= 30 && colunas === 5'h00) on_cycles++;
        end
        checks++;
        if (on_cycles !== 112) begin
            errors++;
            $display("FAIL blink_on_cycles got %0d expected 112", on_cycles);
        end
    endtask

    task automatic test_scroll;
        int           hits [5];
        logic [C-1:0] pat [5];
        logic [N-1:0] img;
        pat[0] = 5'h1E; pat[1] = 5'h0F; pat[2] = 5'h17; pat[3] = 5'h1B; pat[4] = 5'h1D;
        for (int k = 0; k < 5; k++) hits[k] = 0;
        rand_img(img);
        img[4:0] = 5'b00001;
        chaves = 2'b11; padrao = img; carregar = 1'b1;
        for (int i = 0; i < 310; i++) begin
            @(negedge clk);
            carregar = 1'b0;
            checks++;
            if (linhas !== exp_lin || colunas !== exp_col) begin
                errors++;
                $display("FAIL scroll_model i=%0d linhas=%h colunas=%h expected %h %h", i, linhas, colunas, exp_lin, exp_col);
            end
            if (i >= 30 && linhas === 7'h7E)
                for (int k = 0; k < 5; k++) if (colunas === pat[k]) hits[k]++;
        end
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (hits[k] !== 8) begin
                errors++;
                $display("FAIL scroll_offset_%0d row0 cycles got %0d expected 8", k, hits[k]);
            end
        end
    endtask

    task automatic test_random;
        logic [N-1:0] img;
        for (int i = 0; i < 700; i++) begin
            @(negedge clk);
            checks++;
            if (linhas !== exp_lin || colunas !== exp_col) begin
                errors++;
                $display("FAIL random i=%0d chaves=%b linhas=%h colunas=%h expected %h %h", i, chaves, linhas, colunas, exp_lin, exp_col);
            end
            if ($urandom_range(0, 39) == 0) chaves = 2'($urandom_range(0, 3));
            carregar = ($urandom_range(0, 9) == 0);
            rand_img(img);
            padrao = img;
        end
        carregar = 1'b0;
    endtask

    task automatic test_reset_mid;
        logic [N-1:0] img;
        rand_img(img);
        chaves = 2'b11; padrao = img; carregar = 1'b1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            carregar = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (linhas !== 7'h7F || colunas !== 5'h1F) begin
            errors++;
            $display("FAIL reset_mid linhas=%h colunas=%h expected 7f 1f", linhas, colunas);
        end
        @(negedge clk);
        rst = 1'b0;
        // buffers cleared: columns stay dark for the first frame while rows scan
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            checks++;
            if (linhas !== exp_lin || colunas !== exp_col || colunas !== 5'h1F) begin
                errors++;
                $display("FAIL reset_mid_blank i=%0d linhas=%h colunas=%h expected %h 1f", i, linhas, colunas, exp_lin);
            end
        end
    endtask

`ifdef VARREDURA_BLANKING_EN
    task automatic test_blanking;
        int blank;
        blank = 0;
        chaves = 2'b01; padrao = '1; carregar = 1'b1;
        for (int i = 0; i < 58; i++) begin
            @(negedge clk);
            carregar = 1'b0;
            checks++;
            if (linhas !== exp_lin || colunas !== exp_col) begin
                errors++;
                $display("FAIL blank_model i=%0d linhas=%h colunas=%h expected %h %h", i, linhas, colunas, exp_lin, exp_col);
            end
            if (i >= 30 && linhas === 7'h7F && colunas === 5'h1F) blank++;
        end
        checks++;
        if (blank !== 7) begin
            errors++;
            $display("FAIL blank_cycles got %0d expected 7", blank);
        end
    endtask
`endif

    // Sequence and final report
    initial begin
        rst = 1'b1; chaves = 2'b00; padrao = '0; carregar = 1'b0;
        test_reset();
        test_static_load();
        test_tear_free();
        test_blink();
        test_scroll();
        test_random();
        test_reset_mid();
`ifdef VARREDURA_BLANKING_EN
        test_blanking();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
